// File: rtl/vga_sync_monitor.sv
// vga_sync_monitor: recovers pixel position from VGA sync inputs and checks line/frame timing
//   CLK, RST_BTN                           clock, asynchronous active-low reset
//   i_pix_stb                              pixel strobe; inputs sampled and state advanced only when high
//   i_hs, i_vs                             active-low sync inputs
//   o_x, o_y, o_active                     recovered position inside the active window
//   o_locked                               lock FSM is in LOCKED
//   o_line_err, o_frame_err, o_frame_done  one-clock pulses
//   o_err_cnt                              saturating error count
module vga_sync_monitor #(
  parameter int H_TOTAL   = 800,
  parameter int H_SYNC    = 96,
  parameter int H_ACT_STA = 144,
  parameter int H_ACTIVE  = 640,
  parameter int V_TOTAL   = 525,
  parameter int V_SYNC    = 2,
  parameter int V_ACT_STA = 36,
  parameter int V_ACTIVE  = 480
) (
  input  logic       CLK,
  input  logic       RST_BTN,
  input  logic       i_pix_stb,
  input  logic       i_hs,
  input  logic       i_vs,
  output logic [9:0] o_x,
  output logic [8:0] o_y,
  output logic       o_active,
  output logic       o_locked,
  output logic       o_line_err,
  output logic       o_frame_err,
  output logic       o_frame_done,
  output logic [7:0] o_err_cnt
);
  typedef enum logic [1:0] {SEARCH, ACQUIRE, LOCKED} state_t;
  localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
  localparam logic [9:0] H_SW   = 10'(H_SYNC - 1);
  localparam logic [9:0] HA0    = 10'(H_ACT_STA);
  localparam logic [9:0] HA1    = 10'(H_ACT_STA + H_ACTIVE);
  localparam logic [9:0] V_TOT  = 10'(V_TOTAL);
  localparam logic [9:0] V_SW   = 10'(V_SYNC);
  localparam logic [9:0] VA0    = 10'(V_ACT_STA);
  localparam logic [9:0] VA1    = 10'(V_ACT_STA + V_ACTIVE);
  state_t     state_q, state_d;
  logic [9:0] h_q, h_d, v_q, v_d, x_q, x_d;
  logic [8:0] y_q, y_d;
  logic [7:0] err_q, err_d;
  logic       hs_q, vs_q, clean_q, clean_d, act_q, act_d, le_q, fe_q, fd_q;
  logic       hs_fall, hs_rise, vs_fall, vs_rise, line_err, frame_err, track, err;
  always_comb begin
    hs_fall   = hs_q & ~i_hs;
    hs_rise   = ~hs_q & i_hs;
    vs_fall   = vs_q & ~i_vs;
    vs_rise   = ~vs_q & i_vs;
    line_err  = (hs_fall && h_q != H_LAST) || (hs_rise && h_q != H_SW);
    frame_err = (vs_fall && v_q != V_TOT) || (vs_rise && v_q != V_SW);
    track     = state_q != SEARCH;
    err       = track && (line_err || frame_err);
    h_d       = hs_fall ? '0 : (&h_q) ? h_q : h_q + 10'd1;
    v_d       = vs_fall ? '0 : (hs_fall && !(&v_q)) ? v_q + 10'd1 : v_q;
    state_d   = state_q == SEARCH ? (vs_fall ? ACQUIRE : SEARCH)
              : state_q == LOCKED ? (err ? ACQUIRE : LOCKED)
              : (vs_fall && clean_q && !err) ? LOCKED : ACQUIRE;
    // clean_q tracks "no error in ACQUIRE since entry or the last VS fall";
    // it idles at 1 outside ACQUIRE so every entry starts clean
    clean_d   = (vs_fall || state_q != ACQUIRE) ? 1'b1 : clean_q & ~err;
    err_d     = (err && !(&err_q)) ? err_q + 8'd1 : err_q;
    // position outputs derive from next-state values so they align with the counter edge
    act_d     = state_d == LOCKED && h_d >= HA0 && h_d < HA1 && v_d >= VA0 && v_d < VA1;
    x_d       = act_d ? h_d - HA0 : '0;
    y_d       = act_d ? 9'(v_d - VA0) : '0;
  end
  always_ff @(posedge CLK or negedge RST_BTN)
    if (!RST_BTN) begin
      state_q <= SEARCH;
      h_q     <= '0;
      v_q     <= '0;
      hs_q    <= 1'b1;
      vs_q    <= 1'b1;
      clean_q <= 1'b1;
      err_q   <= '0;
      x_q     <= '0;
      y_q     <= '0;
      act_q   <= 1'b0;
      le_q    <= 1'b0;
      fe_q    <= 1'b0;
      fd_q    <= 1'b0;
    end else begin
      le_q <= i_pix_stb & track & line_err;
      fe_q <= i_pix_stb & track & frame_err;
      fd_q <= i_pix_stb & track & vs_fall;
      if (i_pix_stb) begin
        state_q <= state_d;
        h_q     <= h_d;
        v_q     <= v_d;
        hs_q    <= i_hs;
        vs_q    <= i_vs;
        clean_q <= clean_d;
        err_q   <= err_d;
        x_q     <= x_d;
        y_q     <= y_d;
        act_q   <= act_d;
      end
    end
  assign o_x          = x_q;
  assign o_y          = y_q;
  assign o_active     = act_q;
  assign o_locked     = state_q == LOCKED;
  assign o_line_err   = le_q;
  assign o_frame_err  = fe_q;
  assign o_frame_done = fd_q;
  assign o_err_cnt    = err_q;
endmodule

// File: tb/tb_vga_sync_monitor.sv
// tb_vga_sync_monitor: directed checks of vga_sync_monitor on a scaled-down 20x10 timing
module tb_vga_sync_monitor;
  localparam int HT = 20, HSW = 3, HA = 5, HW = 12, VT = 10, VSW = 2, VA = 3, VH = 5;
  logic       CLK = 1'b0, RST_BTN = 1'b0, i_pix_stb = 1'b0, i_hs = 1'b1, i_vs = 1'b1;
  logic [9:0] o_x;
  logic [8:0] o_y;
  logic       o_active, o_locked, o_line_err, o_frame_err, o_frame_done;
  logic [7:0] o_err_cnt;
  int total = 0, bad = 0;
  int n_le = 0, n_fe = 0, n_fd = 0, n_lk = 0, n_act = 0;
  always #5 CLK = ~CLK;
  vga_sync_monitor #(
    .H_TOTAL(HT), .H_SYNC(HSW), .H_ACT_STA(HA), .H_ACTIVE(HW),
    .V_TOTAL(VT), .V_SYNC(VSW), .V_ACT_STA(VA), .V_ACTIVE(VH)
  ) dut (
    .CLK(CLK), .RST_BTN(RST_BTN), .i_pix_stb(i_pix_stb), .i_hs(i_hs), .i_vs(i_vs),
    .o_x(o_x), .o_y(o_y), .o_active(o_active), .o_locked(o_locked),
    .o_line_err(o_line_err), .o_frame_err(o_frame_err), .o_frame_done(o_frame_done),
    .o_err_cnt(o_err_cnt)
  );
  // pulses are counted every clock, so a pulse held longer than one CLK inflates the counts
  always @(negedge CLK) begin
    n_le += int'(o_line_err);
    n_fe += int'(o_frame_err);
    n_fd += int'(o_frame_done);
    if ((o_line_err || o_frame_err) && o_locked) n_lk++;
  end
  task automatic strobe(input logic hs, input logic vs);
    i_hs = hs;
    i_vs = vs;
    i_pix_stb = 1'b1;
    @(posedge CLK);
    #1;
    i_pix_stb = 1'b0;
    n_act += int'(o_active);
    repeat (3) @(posedge CLK);
    #1;
  endtask
  // VS falls one strobe after the HS fall that opens line 0 and rises one strobe into line 2
  function automatic logic vs_at(input int l, input int p);
    return (p == 0) ? !(l == 1 || l == 2) : !(l == 0 || l == 1);
  endfunction
  task automatic seg(input int l, input int p0, input int p1, input int hsw);
    for (int p = p0; p <= p1; p++) strobe(logic'(p >= hsw), vs_at(l, p));
  endtask
  task automatic lines(input int a, input int b);
    for (int l = a; l <= b; l++) seg(l, 0, HT - 1, HSW);
  endtask
  task automatic test_reset;
    repeat (2) @(posedge CLK);
    #1;
    total++;
    if ({o_x, o_y, o_active, o_locked, o_line_err, o_frame_err, o_frame_done, o_err_cnt} !== 32'd0) begin
      bad++;
      $display("FAIL reset_outputs got=%h want=0", {o_x, o_y, o_active, o_locked, o_line_err, o_frame_err, o_frame_done, o_err_cnt});
    end
    RST_BTN = 1'b1;
    repeat (2) @(posedge CLK);
    #1;
    total++;
    if ({o_locked, o_err_cnt, o_active} !== 10'd0) begin
      bad++;
      $display("FAIL release_idle got=%h want=0", {o_locked, o_err_cnt, o_active});
    end
  endtask
  task automatic test_lock;
    int le0 = n_le, fe0 = n_fe, fd0 = n_fd;
    lines(0, 0);
    total++;
    if ({o_locked, 8'(n_fd - fd0)} !== 9'd0) begin
      bad++;
      $display("FAIL first_vs_fall got locked=%0d done=%0d want 0 0", o_locked, n_fd - fd0);
    end
    lines(1, 9);
    total++;
    if (o_locked !== 1'b0) begin
      bad++;
      $display("FAIL acquire_no_lock got=%0d want=0", o_locked);
    end
    lines(0, 9);
    lines(0, 9);
    total++;
    if (o_locked !== 1'b1 || o_err_cnt !== 8'd0) begin
      bad++;
      $display("FAIL lock_3frames got locked=%0d errs=%0d want 1 0", o_locked, o_err_cnt);
    end
    total++;
    if (n_fd - fd0 != 2 || n_le - le0 != 0 || n_fe - fe0 != 0) begin
      bad++;
      $display("FAIL lock_pulses got done=%0d le=%0d fe=%0d want 2 0 0", n_fd - fd0, n_le - le0, n_fe - fe0);
    end
  endtask
  task automatic test_active;
    int a0 = n_act;
    for (int l = 0; l < VT; l++)
      for (int p = 0; p < HT; p++) begin
        strobe(logic'(p >= HSW), vs_at(l, p));
        if (l == 3 && p == 4) begin
          total++;
          if (o_active !== 1'b0) begin bad++; $display("FAIL before_first_px got=%0d want=0", o_active); end
        end
        if (l == 3 && p == 5) begin
          total++;
          if ({o_active, o_x, o_y} !== {1'b1, 10'd0, 9'd0}) begin bad++; $display("FAIL first_px got a=%0d x=%0d y=%0d want 1 0 0", o_active, o_x, o_y); end
        end
        if (l == 5 && p == 10) begin
          total++;
          if ({o_active, o_x, o_y} !== {1'b1, 10'd5, 9'd2}) begin bad++; $display("FAIL mid_px got a=%0d x=%0d y=%0d want 1 5 2", o_active, o_x, o_y); end
        end
        if (l == 7 && p == 16) begin
          total++;
          if ({o_active, o_x, o_y} !== {1'b1, 10'd11, 9'd4}) begin bad++; $display("FAIL last_px got a=%0d x=%0d y=%0d want 1 11 4", o_active, o_x, o_y); end
        end
        if (l == 7 && p == 17) begin
          total++;
          if ({o_active, o_x, o_y} !== 20'd0) begin bad++; $display("FAIL past_last_px got a=%0d x=%0d y=%0d want 0 0 0", o_active, o_x, o_y); end
        end
        if (l == 8 && p == 5) begin
          total++;
          if (o_active !== 1'b0) begin bad++; $display("FAIL below_window got=%0d want=0", o_active); end
        end
      end
    total++;
    if (n_act - a0 != HW * VH) begin
      bad++;
      $display("FAIL active_count got=%0d want=%0d", n_act - a0, HW * VH);
    end
  endtask
  task automatic test_line_len;
    int le0 = n_le, lk0 = n_lk;
    lines(0, 3);
    seg(4, 0, HT, HSW);
    lines(5, 5);
    total++;
    if (n_le - le0 != 1 || o_err_cnt !== 8'd1 || o_locked !== 1'b0) begin
      bad++;
      $display("FAIL long_line got le=%0d errs=%0d locked=%0d want 1 1 0", n_le - le0, o_err_cnt, o_locked);
    end
    total++;
    if (n_lk - lk0 != 0) begin
      bad++;
      $display("FAIL locked_during_err got=%0d want=0", n_lk - lk0);
    end
    lines(6, 9);
    lines(0, 0);
    total++;
    if (o_locked !== 1'b1 || n_le - le0 != 1) begin
      bad++;
      $display("FAIL relock_long got locked=%0d le=%0d want 1 1", o_locked, n_le - le0);
    end
    lines(1, 9);
  endtask
  task automatic test_hs_width;
    int le0 = n_le, fe0, fd0;
    lines(0, 3);
    seg(4, 0, HT - 1, HSW - 1);
    lines(5, 9);
    total++;
    if (n_le - le0 != 1 || o_err_cnt !== 8'd2 || o_locked !== 1'b0) begin
      bad++;
      $display("FAIL short_hs got le=%0d errs=%0d locked=%0d want 1 2 0", n_le - le0, o_err_cnt, o_locked);
    end
    lines(0, 9);
    lines(0, VT - 2);
    total++;
    if (o_locked !== 1'b1) begin
      bad++;
      $display("FAIL relock_hs got=%0d want=1", o_locked);
    end
    fe0 = n_fe;
    fd0 = n_fd;
    lines(0, 0);
    total++;
    if (n_fe - fe0 != 1 || n_fd - fd0 != 1 || o_err_cnt !== 8'd3 || o_locked !== 1'b0) begin
      bad++;
      $display("FAIL short_frame got fe=%0d done=%0d errs=%0d locked=%0d want 1 1 3 0", n_fe - fe0, n_fd - fd0, o_err_cnt, o_locked);
    end
    lines(1, 9);
    lines(0, 0);
    total++;
    if (o_locked !== 1'b1) begin
      bad++;
      $display("FAIL relock_frame got=%0d want=1", o_locked);
    end
  endtask
  task automatic test_stall;
    int le0, fe0, fd0, chg = 0;
    logic [30:0] snap;
    lines(1, 3);
    seg(4, 0, 8, HSW);
    snap = {o_x, o_y, o_active, o_locked, o_err_cnt};
    total++;
    if (snap !== {10'd3, 9'd1, 1'b1, 1'b1, 8'd3}) begin
      bad++;
      $display("FAIL pre_stall got=%h want=%h", snap, {10'd3, 9'd1, 1'b1, 1'b1, 8'd3});
    end
    le0 = n_le;
    fe0 = n_fe;
    fd0 = n_fd;
    repeat (50) begin
      @(negedge CLK);
      if ({o_x, o_y, o_active, o_locked, o_err_cnt} !== snap) chg++;
    end
    total++;
    if (chg != 0 || n_le + n_fe + n_fd - le0 - fe0 - fd0 != 0) begin
      bad++;
      $display("FAIL stall got changes=%0d pulses=%0d want 0 0", chg, n_le + n_fe + n_fd - le0 - fe0 - fd0);
    end
    #1;
    seg(4, 9, HT - 1, HSW);
    lines(5, 9);
    lines(0, 0);
    total++;
    if (n_le - le0 != 0 || n_fe - fe0 != 0 || o_locked !== 1'b1 || o_err_cnt !== 8'd3) begin
      bad++;
      $display("FAIL after_stall got le=%0d fe=%0d locked=%0d errs=%0d want 0 0 1 3", n_le - le0, n_fe - fe0, o_locked, o_err_cnt);
    end
  endtask
  task automatic test_err_sat;
    for (int i = 0; i < 300; i++) strobe(logic'(i % 2), 1'b1);
    total++;
    if (o_err_cnt !== 8'd255) begin
      bad++;
      $display("FAIL err_saturate got=%0d want=255", o_err_cnt);
    end
    lines(0, 9);
    lines(0, 0);
    total++;
    if (o_locked !== 1'b1 || o_err_cnt !== 8'd255) begin
      bad++;
      $display("FAIL sat_recover got locked=%0d errs=%0d want 1 255", o_locked, o_err_cnt);
    end
  endtask
  task automatic test_reset_mid;
    int le0, fe0, fd0;
    lines(1, 4);
    seg(5, 0, 9, HSW);
    total++;
    if ({o_locked, o_active, o_x, o_y} !== {1'b1, 1'b1, 10'd4, 9'd2}) begin
      bad++;
      $display("FAIL pre_reset got l=%0d a=%0d x=%0d y=%0d want 1 1 4 2", o_locked, o_active, o_x, o_y);
    end
    RST_BTN = 1'b0;
    #2;
    total++;
    if ({o_x, o_y, o_active, o_locked, o_line_err, o_frame_err, o_frame_done, o_err_cnt} !== 32'd0) begin
      bad++;
      $display("FAIL async_reset got=%h want=0", {o_x, o_y, o_active, o_locked, o_line_err, o_frame_err, o_frame_done, o_err_cnt});
    end
    repeat (3) @(posedge CLK);
    #1;
    RST_BTN = 1'b1;
    le0 = n_le;
    fe0 = n_fe;
    fd0 = n_fd;
    seg(5, 10, HT - 1, HSW);
    lines(6, 9);
    lines(0, 0);
    total++;
    if (o_locked !== 1'b0 || n_le + n_fe + n_fd - le0 - fe0 - fd0 != 0) begin
      bad++;
      $display("FAIL search_after_reset got locked=%0d pulses=%0d want 0 0", o_locked, n_le + n_fe + n_fd - le0 - fe0 - fd0);
    end
    lines(1, 9);
    lines(0, 0);
    total++;
    if (o_locked !== 1'b1 || n_fd - fd0 != 1 || o_err_cnt !== 8'd0 || n_le - le0 != 0) begin
      bad++;
      $display("FAIL relock_reset got locked=%0d done=%0d errs=%0d le=%0d want 1 1 0 0", o_locked, n_fd - fd0, o_err_cnt, n_le - le0);
    end
  endtask
  initial begin
    test_reset;
    test_lock;
    test_active;
    test_line_len;
    test_hs_width;
    test_stall;
    test_err_sat;
    test_reset_mid;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
